// File: rtl/clks_alot_p.sv
// Types and widths shared by the clks_alot recovery channel blocks.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH    = 12;
  localparam int LOCKIN_CTRL_TIMEOUT_W = 16;
  localparam int LOCKIN_CTRL_VIOL_W    = 8;

  typedef enum logic {
    PIN_CAME_LATE  = 1'b0,
    PIN_CAME_EARLY = 1'b1
  } drift_direction_e;

  typedef struct packed {
    logic                          full_drift_direction_en;
    logic [RATE_COUNTER_WIDTH-1:0] half_rate_min;
    logic [RATE_COUNTER_WIDTH-1:0] half_rate_max;
  } half_rate_limits_s;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACQUIRE = 3'd2,
    TRACK   = 3'd3,
    LOCKED  = 3'd4
  } lockin_ctrl_state_e;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle: clock, clock enable and synchronous active-high reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/lockin_ctrl_pkg.sv
// Controller-local constants and state classification helpers for lockin_ctrl.
package lockin_ctrl_pkg;
  import clks_alot_p::*;

  localparam int STATS_W   = 8;
  localparam int STATS_MAX = 255;

  function automatic logic is_run_state(lockin_ctrl_state_e s);
    return (s == ACQUIRE) || (s == TRACK) || (s == LOCKED);
  endfunction

  function automatic logic is_supervised(lockin_ctrl_state_e s);
    return (s == TRACK) || (s == LOCKED);
  endfunction

endpackage

// File: rtl/lockin_ctrl_sat_counter.sv
// Saturating up-counter with clear; hit_o flags that the current increment reaches LIMIT.
module lockin_ctrl_sat_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         clk_en,
  input  logic         sync_rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  localparam logic [W-1:0] LIMIT_C  = W'(LIMIT);
  localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT_C)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = inc_i && (count_q >= LIMIT_M1);

endmodule

// File: rtl/lockin_ctrl.sv
// Lock-in sequencing controller: acquire, track, lock, and forced re-acquisition.
// Relock statistics counter is built only when LOCKIN_CTRL_STATS_EN is defined.
//   state   | meaning
//   IDLE    | channel disabled, comparator off
//   CLEAR   | one clk_en cycle clearing lock-in state and supervision counters
//   ACQUIRE | waiting for the first rate capture
//   TRACK   | rate captured, waiting for lock under timeout supervision
//   LOCKED  | locked; lock loss falls back to TRACK
module lockin_ctrl
  import common_p::*;
  import clks_alot_p::*;
  import lockin_ctrl_pkg::*;
#(
  parameter int RATE_W         = RATE_COUNTER_WIDTH,
  parameter int MAX_VIOLATIONS = 4,
  parameter int ACQ_TIMEOUT    = 16'hFFFF
) (
  input  clk_dom_s           sys_dom_i,
  input  logic               enable_i,
  input  logic               restart_i,
  input  half_rate_limits_s  half_rate_limits_i,
  input  logic [RATE_W-1:0]  rate_accumulator_i,
  input  logic               update_rate_i,
  input  logic               rate_violation_i,
  input  logic               smaller_data_bit_detected_i,
  input  logic               drift_detected_i,
  input  drift_direction_e   drift_direction_i,
  input  logic               locked_in_i,
  output logic               lockin_en_o,
  output logic               clear_state_o,
  output logic               active_rate_valid_o,
  output logic [RATE_W-1:0]  active_rate_o,
  output drift_direction_e   active_drift_direction_o,
  output half_rate_limits_s  half_rate_limits_o,
  output lockin_ctrl_state_e state_o,
  output logic               lock_lost_o,
  output logic               timeout_o,
  output logic [7:0]         relock_count_o
);

  logic clk, clk_en, sync_rst;

  lockin_ctrl_state_e state_q, state_d;
  logic [RATE_W-1:0]  active_rate_q, active_rate_d;
  logic               valid_q, valid_d;
  logic               dir_known_q, dir_known_d;
  drift_direction_e   dir_q, dir_d;
  logic               lock_lost_q, lock_lost_d;
  logic               timeout_q, timeout_d;

  logic capture, viol_inc, viol_clr, viol_hit, tmo_inc, tmo_clr, tmo_hit;
  logic [LOCKIN_CTRL_VIOL_W-1:0]    viol_cnt_unused;
  logic [LOCKIN_CTRL_TIMEOUT_W-1:0] tmo_cnt_unused;

  assign clk      = sys_dom_i.clk;
  assign clk_en   = sys_dom_i.clk_en;
  assign sync_rst = sys_dom_i.sync_rst;

  assign capture  = is_run_state(state_q) && enable_i && !restart_i && update_rate_i;
  // A capture or a shrinking data bit proves the rate is still being refined.
  assign viol_inc = is_supervised(state_q) && valid_q && rate_violation_i && !update_rate_i;
  assign viol_clr = update_rate_i || smaller_data_bit_detected_i || (state_d == CLEAR);
  assign tmo_inc  = (state_q == TRACK);
  assign tmo_clr  = (state_d != TRACK);

  lockin_ctrl_sat_counter #(.W(LOCKIN_CTRL_VIOL_W), .LIMIT(MAX_VIOLATIONS)) u_viol_cnt (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .clr_i(viol_clr), .inc_i(viol_inc), .count_o(viol_cnt_unused), .hit_o(viol_hit)
  );

  lockin_ctrl_sat_counter #(.W(LOCKIN_CTRL_TIMEOUT_W), .LIMIT(ACQ_TIMEOUT)) u_tmo_cnt (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .clr_i(tmo_clr), .inc_i(tmo_inc), .count_o(tmo_cnt_unused), .hit_o(tmo_hit)
  );

  always_comb begin
    state_d     = state_q;
    lock_lost_d = 1'b0;
    timeout_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else if (restart_i) begin
      state_d = CLEAR;
    end else begin
      unique case (state_q)
        IDLE:    state_d = CLEAR;
        CLEAR:   state_d = ACQUIRE;
        ACQUIRE: if (update_rate_i) state_d = TRACK;
        TRACK: begin
          if (tmo_hit) begin
            state_d   = CLEAR;
            timeout_d = 1'b1;
          end else if (viol_hit) begin
            state_d = CLEAR;
          end else if (locked_in_i) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (viol_hit) begin
            state_d = CLEAR;
          end else if (!locked_in_i) begin
            state_d     = TRACK;
            lock_lost_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    active_rate_d = active_rate_q;
    valid_d       = valid_q;
    dir_d         = dir_q;
    dir_known_d   = dir_known_q;
    if (capture) begin
      active_rate_d = rate_accumulator_i;
      valid_d       = 1'b1;
      if (!dir_known_q && drift_detected_i) begin
        dir_d       = drift_direction_i;
        dir_known_d = 1'b1;
      end
    end
    if (state_d == CLEAR) begin
      valid_d     = 1'b0;
      dir_known_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q       <= IDLE;
      active_rate_q <= '0;
      valid_q       <= 1'b0;
      dir_q         <= PIN_CAME_LATE;
      dir_known_q   <= 1'b0;
      lock_lost_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (clk_en) begin
      state_q       <= state_d;
      active_rate_q <= active_rate_d;
      valid_q       <= valid_d;
      dir_q         <= dir_d;
      dir_known_q   <= dir_known_d;
      lock_lost_q   <= lock_lost_d;
      timeout_q     <= timeout_d;
    end
  end

  // Until a direction is learned the lock-in must search both drift directions.
  always_comb begin
    half_rate_limits_o = half_rate_limits_i;
    if (!dir_known_q) half_rate_limits_o.full_drift_direction_en = 1'b1;
  end

  assign lockin_en_o              = is_run_state(state_q);
  assign clear_state_o            = (state_q == CLEAR);
  assign active_rate_valid_o      = valid_q;
  assign active_rate_o            = active_rate_q;
  assign active_drift_direction_o = dir_known_q ? dir_q : PIN_CAME_LATE;
  assign state_o                  = state_q;
  assign lock_lost_o              = lock_lost_q;
  assign timeout_o                = timeout_q;

`ifdef LOCKIN_CTRL_STATS_EN
  logic stats_inc;
  logic stats_hit_unused;

  assign stats_inc = (state_d == CLEAR) && is_supervised(state_q);

  lockin_ctrl_sat_counter #(.W(STATS_W), .LIMIT(STATS_MAX)) u_stats_cnt (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .clr_i(1'b0), .inc_i(stats_inc), .count_o(relock_count_o), .hit_o(stats_hit_unused)
  );
`else
  assign relock_count_o = '0;
`endif

endmodule

// File: tb/tb_lockin_ctrl.sv
// Self-checking bench for lockin_ctrl: directed vector table, corner sequences, random vs reference model.
module tb_lockin_ctrl;
  import common_p::*;
  import clks_alot_p::*;

  localparam int RATE_W = RATE_COUNTER_WIDTH;
  localparam int MAXV   = 4;
  localparam int TMO    = 10;
  localparam int LIM_W  = $bits(half_rate_limits_s);
`ifdef LOCKIN_CTRL_STATS_EN
  localparam int EXP_RELOCK = 3;
`else
  localparam int EXP_RELOCK = 0;
`endif

  logic clk, ce, rst;
  clk_dom_s sys_dom;
  logic en, rs, upd, viol, sm, drift, lk;
  drift_direction_e dd;
  logic [RATE_W-1:0] acc;
  half_rate_limits_s lim_i, lim_o;

  logic lockin_en, clear_state, valid, lock_lost, timeout;
  logic [RATE_W-1:0] rate;
  drift_direction_e dir_o;
  lockin_ctrl_state_e state;
  logic [7:0] relock;

  int n_checks = 0;
  int n_err    = 0;

  assign sys_dom = '{clk: clk, clk_en: ce, sync_rst: rst};

  lockin_ctrl #(.RATE_W(RATE_W), .MAX_VIOLATIONS(MAXV), .ACQ_TIMEOUT(TMO)) dut (
    .sys_dom_i(sys_dom),
    .enable_i(en),
    .restart_i(rs),
    .half_rate_limits_i(lim_i),
    .rate_accumulator_i(acc),
    .update_rate_i(upd),
    .rate_violation_i(viol),
    .smaller_data_bit_detected_i(sm),
    .drift_detected_i(drift),
    .drift_direction_i(dd),
    .locked_in_i(lk),
    .lockin_en_o(lockin_en),
    .clear_state_o(clear_state),
    .active_rate_valid_o(valid),
    .active_rate_o(rate),
    .active_drift_direction_o(dir_o),
    .half_rate_limits_o(lim_o),
    .state_o(state),
    .lock_lost_o(lock_lost),
    .timeout_o(timeout),
    .relock_count_o(relock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: mode plus plain integer bookkeeping of the rules.
  lockin_ctrl_state_e m_state;
  logic [RATE_W-1:0]  m_rate;
  bit m_valid, m_known, m_lost, m_tmo;
  drift_direction_e m_dir;
  int m_viol, m_track, m_relock;

  task automatic model_update();
    lockin_ctrl_state_e nxt;
    bit supervised, viol_evt, viol_limit, track_limit;
    if (rst) begin
      m_state = IDLE; m_rate = '0; m_valid = 0; m_known = 0; m_dir = PIN_CAME_LATE;
      m_lost = 0; m_tmo = 0; m_viol = 0; m_track = 0; m_relock = 0;
      return;
    end
    if (!ce) return;
    supervised  = (m_state == TRACK) || (m_state == LOCKED);
    viol_evt    = supervised && m_valid && viol && !upd;
    viol_limit  = viol_evt && (m_viol + 1 >= MAXV);
    track_limit = (m_state == TRACK) && (m_track + 1 >= TMO);
    nxt = m_state;
    m_lost = 0;
    m_tmo  = 0;
    if (!en) nxt = IDLE;
    else if (rs) nxt = CLEAR;
    else if (m_state == IDLE) nxt = CLEAR;
    else if (m_state == CLEAR) nxt = ACQUIRE;
    else if (m_state == ACQUIRE) begin
      if (upd) nxt = TRACK;
    end else if (m_state == TRACK) begin
      if (track_limit) begin nxt = CLEAR; m_tmo = 1; end
      else if (viol_limit) nxt = CLEAR;
      else if (lk) nxt = LOCKED;
    end else begin
      if (viol_limit) nxt = CLEAR;
      else if (!lk) begin nxt = TRACK; m_lost = 1; end
    end
    if ((m_state != IDLE) && (m_state != CLEAR) && en && !rs && upd) begin
      m_rate  = acc;
      m_valid = 1;
      if (!m_known && drift) begin m_dir = dd; m_known = 1; end
    end
    if (nxt == CLEAR) begin
      m_valid = 0;
      m_known = 0;
`ifdef LOCKIN_CTRL_STATS_EN
      if (supervised && m_relock < 255) m_relock++;
`endif
    end
    if (upd || sm || nxt == CLEAR) m_viol = 0;
    else if (viol_evt && m_viol < MAXV) m_viol++;
    if (nxt == TRACK && m_state == TRACK) m_track++;
    else m_track = 0;
    m_state = nxt;
  endtask

  task automatic check_model();
    half_rate_limits_s e_lim;
    logic e_en, e_clr;
    drift_direction_e e_dir;
    e_en  = (m_state == ACQUIRE) || (m_state == TRACK) || (m_state == LOCKED);
    e_clr = (m_state == CLEAR);
    e_dir = m_known ? m_dir : PIN_CAME_LATE;
    e_lim = lim_i;
    if (!m_known) e_lim.full_drift_direction_en = 1'b1;
    n_checks++;
    if (state !== m_state || lockin_en !== e_en || clear_state !== e_clr || valid !== m_valid ||
        rate !== m_rate || dir_o !== e_dir || lim_o !== e_lim || lock_lost !== m_lost ||
        timeout !== m_tmo || relock !== 8'(m_relock)) begin
      n_err++;
      $display("FAIL model t=%0t got/exp: state=%0d/%0d en=%0b/%0b clr=%0b/%0b valid=%0b/%0b rate=%0d/%0d dir=%0d/%0d lim=%h/%h lost=%0b/%0b tmo=%0b/%0b relock=%0d/%0d",
               $time, state, m_state, lockin_en, e_en, clear_state, e_clr, valid, m_valid, rate, m_rate,
               dir_o, e_dir, lim_o, e_lim, lock_lost, m_lost, timeout, m_tmo, relock, m_relock);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ce = 1'b1; en = 1'b1; rs = 1'b0; upd = 1'b0;
    viol = 1'b0; sm = 1'b0; drift = 1'b0; lk = 1'b0;
  endtask

  typedef struct {
    logic rst, en, upd;
    logic [RATE_W-1:0] acc;
    logic viol, drift;
    drift_direction_e dd;
    logic lk;
    lockin_ctrl_state_e st;
    logic valid;
    logic [RATE_W-1:0] rate;
    drift_direction_e dir;
    logic fde, lost;
  } vec_t;

  vec_t tbl[11];

  initial begin
    //            rst en  upd acc      viol drift dd              lk    state    valid rate     dir             fde lost
    tbl[0]  = '{'1, '0, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '0,   IDLE,    '0, 12'd0,   PIN_CAME_LATE,  '1, '0};
    tbl[1]  = '{'0, '1, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '0,   CLEAR,   '0, 12'd0,   PIN_CAME_LATE,  '1, '0};
    tbl[2]  = '{'0, '1, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '0,   ACQUIRE, '0, 12'd0,   PIN_CAME_LATE,  '1, '0};
    tbl[3]  = '{'0, '1, '0, 12'd0,   '1, '0, PIN_CAME_LATE,  '0,   ACQUIRE, '0, 12'd0,   PIN_CAME_LATE,  '1, '0};
    tbl[4]  = '{'0, '1, '1, 12'd100, '0, '0, PIN_CAME_EARLY, '0,   TRACK,   '1, 12'd100, PIN_CAME_LATE,  '1, '0};
    tbl[5]  = '{'0, '1, '1, 12'd120, '0, '1, PIN_CAME_EARLY, '0,   TRACK,   '1, 12'd120, PIN_CAME_EARLY, '0, '0};
    tbl[6]  = '{'0, '1, '1, 12'd130, '0, '1, PIN_CAME_LATE,  '0,   TRACK,   '1, 12'd130, PIN_CAME_EARLY, '0, '0};
    tbl[7]  = '{'0, '1, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '1,   LOCKED,  '1, 12'd130, PIN_CAME_EARLY, '0, '0};
    tbl[8]  = '{'0, '1, '1, 12'd140, '0, '0, PIN_CAME_LATE,  '1,   LOCKED,  '1, 12'd140, PIN_CAME_EARLY, '0, '0};
    tbl[9]  = '{'0, '1, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '0,   TRACK,   '1, 12'd140, PIN_CAME_EARLY, '0, '1};
    tbl[10] = '{'0, '1, '0, 12'd0,   '0, '0, PIN_CAME_LATE,  '0,   TRACK,   '1, 12'd140, PIN_CAME_EARLY, '0, '0};

    idle_inputs();
    rst = 1'b1; en = 1'b0; acc = '0; dd = PIN_CAME_LATE;
    lim_i = '{full_drift_direction_en: 1'b0, half_rate_min: 12'h010, half_rate_max: 12'h200};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; upd = tbl[i].upd; acc = tbl[i].acc;
      viol = tbl[i].viol; drift = tbl[i].drift; dd = tbl[i].dd; lk = tbl[i].lk;
      tick();
      check($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("row%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      check($sformatf("row%0d_rate", i), 32'(rate), 32'(tbl[i].rate));
      check($sformatf("row%0d_dir", i), 32'(dir_o), 32'(tbl[i].dir));
      check($sformatf("row%0d_fde", i), 32'(lim_o.full_drift_direction_en), 32'(tbl[i].fde));
      check($sformatf("row%0d_lost", i), 32'(lock_lost), 32'(tbl[i].lost));
    end

    // Violation limit inside LOCKED (timeout supervision is off there).
    idle_inputs(); lk = 1'b1;
    tick();
    check("viol_enter_locked", 32'(state), 32'(LOCKED));
    viol = 1'b1;
    repeat (3) tick();
    check("viol_three_no_clear", 32'(state), 32'(LOCKED));
    upd = 1'b1; acc = 12'd200;
    tick();
    upd = 1'b0;
    check("viol_capture_wins", 32'(rate), 32'd200);
    repeat (3) tick();
    check("viol_three_after_update", 32'(state), 32'(LOCKED));
    tick();
    check("viol_fourth_clear", 32'(state), 32'(CLEAR));
    check("viol_fourth_valid", 32'(valid), 32'd0);
    viol = 1'b0;
    tick();
    check("viol_then_acquire", 32'(state), 32'(ACQUIRE));
    check("viol_dir_forgotten", 32'(dir_o), 32'(PIN_CAME_LATE));

    // Timeout after TMO cycles in TRACK, pulse held across clk_en-low cycles.
    idle_inputs(); upd = 1'b1; acc = 12'd50;
    tick();
    upd = 1'b0;
    check("tmo_enter_track", 32'(state), 32'(TRACK));
    for (int i = 1; i <= TMO; i++) begin
      tick();
      check($sformatf("tmo_state_%0d", i), 32'(state), (i < TMO) ? 32'(TRACK) : 32'(CLEAR));
      check($sformatf("tmo_pulse_%0d", i), 32'(timeout), (i == TMO) ? 32'd1 : 32'd0);
    end
    ce = 1'b0;
    repeat (2) tick();
    check("tmo_pulse_held_no_ce", 32'(timeout), 32'd1);
    check("tmo_state_held_no_ce", 32'(state), 32'(CLEAR));
    ce = 1'b1;
    tick();
    check("tmo_pulse_end", 32'(timeout), 32'd0);
    check("tmo_then_acquire", 32'(state), 32'(ACQUIRE));

    // Lock loss keeps the rate; disable beats restart.
    idle_inputs(); upd = 1'b1; acc = 12'd77;
    tick();
    upd = 1'b0; lk = 1'b1;
    tick();
    check("loss_locked", 32'(state), 32'(LOCKED));
    lk = 1'b0;
    tick();
    check("loss_state", 32'(state), 32'(TRACK));
    check("loss_pulse", 32'(lock_lost), 32'd1);
    check("loss_rate_kept", 32'(rate), 32'd77);
    check("loss_valid_kept", 32'(valid), 32'd1);
    tick();
    check("loss_pulse_end", 32'(lock_lost), 32'd0);
    rs = 1'b1; en = 1'b0;
    tick();
    check("prio_idle", 32'(state), 32'(IDLE));
    check("prio_lockin_off", 32'(lockin_en), 32'd0);

    // Relock statistics from three restarts out of TRACK.
    idle_inputs(); rst = 1'b1; en = 1'b0;
    tick();
    idle_inputs();
    repeat (2) tick();
    upd = 1'b1;
    tick();
    upd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs = 1'b1;
      tick();
      check($sformatf("stats_clear_%0d", i), 32'(clear_state), 32'd1);
      rs = 1'b0;
      tick();
      upd = 1'b1;
      tick();
      upd = 1'b0;
    end
    check("stats_relock_count", 32'(relock), 32'(EXP_RELOCK));

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ce    = ($urandom_range(0, 9) != 0);
      en    = ($urandom_range(0, 49) != 0);
      rs    = ($urandom_range(0, 79) == 0);
      upd   = ($urandom_range(0, 6) == 0);
      viol  = ($urandom_range(0, 2) == 0);
      sm    = ($urandom_range(0, 29) == 0);
      drift = ($urandom_range(0, 1) == 1);
      dd    = ($urandom_range(0, 1) == 1) ? PIN_CAME_EARLY : PIN_CAME_LATE;
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      acc   = RATE_W'($urandom);
      if ($urandom_range(0, 99) == 0) lim_i = LIM_W'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lockin_ctrl.md
Name: lockin_ctrl

Overview:
- Sequencing controller for the lock-in datapath: owns the active rate register, the loop-back drift direction, lockin enable and clear-state.
- Acquires an initial rate, tracks until lock, and supervises violations, timeouts and lock loss, forcing re-acquisition when needed.
- Sits between the rate accumulator / edge filter and the lock-in comparator inside each clks_alot recovery channel.

Parameters:
- RATE_W, clks_alot_p::RATE_COUNTER_WIDTH: width of the rate and accumulator buses.
- MAX_VIOLATIONS, 4: consecutive rate violations that force re-acquisition (1..255).
- ACQ_TIMEOUT, 16'hFFFF: clk_en cycles allowed in TRACK before re-acquisition (1..65535).

Ports:
- sys_dom_i  in  common_p::clk_dom_s  carries clk, clk_en, and sync_rst; reset is synchronous, active-high.
- enable_i  in  1  channel enable.
- restart_i  in  1  request re-acquisition.
- half_rate_limits_i  in  clks_alot_p::half_rate_limits_s  configuration.
- rate_accumulator_i  in  RATE_W  current measured rate.
- update_rate_i  in  1  from lock-in.
- rate_violation_i  in  1  from lock-in.
- smaller_data_bit_detected_i  in  1  from lock-in.
- drift_detected_i  in  1  from lock-in.
- drift_direction_i  in  clks_alot_p::drift_direction_e  from lock-in.
- locked_in_i  in  1  from lock-in.
- lockin_en_o  out  1  enables the lock-in comparator.
- clear_state_o  out  1  clears lock-in state.
- active_rate_valid_o  out  1  active rate holds a captured value.
- active_rate_o  out  RATE_W  captured active rate.
- active_drift_direction_o  out  clks_alot_p::drift_direction_e  drift direction fed back to lock-in.
- half_rate_limits_o  out  clks_alot_p::half_rate_limits_s  configuration forwarded to lock-in.
- state_o  out  clks_alot_p::lockin_ctrl_state_e  current FSM state.
- lock_lost_o  out  1  one-cycle pulse.
- timeout_o  out  1  one-cycle pulse.
- relock_count_o  out  8  statistics counter.

Behaviour:
- Every register updates only when clk_en is high. sync_rst overrides clk_en.
- Reset values:
  - state = IDLE.
  - active_rate_o = 0; active_rate_valid_o = 0; dir_known = 0.
  - Violation counter = 0; timeout counter = 0; relock_count_o = 0.
  - All pulse outputs = 0.
- FSM states:
  - IDLE: lockin_en_o = 0.
  - CLEAR: clear_state_o = 1.
  - ACQUIRE, TRACK, LOCKED: lockin_en_o = 1.
  - clear_state_o = (state == CLEAR), decoded combinationally.
- Transition priority: sync_rst, then ~enable_i → IDLE, then restart_i → CLEAR, then the per-state rules below.
- IDLE → CLEAR when enable_i is high.
- CLEAR lasts exactly one clk_en cycle, then → ACQUIRE. On entry the block clears:
  - active_rate_valid_o and dir_known;
  - the violation counter and the timeout counter.
- ACQUIRE: on update_rate_i, capture active_rate_o = rate_accumulator_i, set valid = 1, → TRACK. Violations are ignored here because valid = 0.
- TRACK:
  - Capture on update_rate_i.
  - Timeout counter increments every clk_en cycle. On reaching ACQ_TIMEOUT: pulse timeout_o, → CLEAR.
  - locked_in_i → LOCKED; the timeout counter is reset.
- LOCKED:
  - Capture on update_rate_i.
  - On locked_in_i falling: pulse lock_lost_o, → TRACK. Rate and direction are retained.
- Violations (TRACK and LOCKED):
  - rate_violation_i without update_rate_i increments the violation counter (saturating).
  - Reaching MAX_VIOLATIONS → CLEAR.
  - Any update_rate_i resets the counter, including smaller_data_bit_detected_i; the capture wins when both are high.
- Direction latch:
  - Taken on the first drift_detected_i && update_rate_i while dir_known = 0: latch drift_direction_i and set dir_known = 1.
  - Only re-latched after CLEAR.
- Direction outputs:
  - While dir_known = 0: active_drift_direction_o = PIN_CAME_LATE and half_rate_limits_o.full_drift_direction_en = 1.
  - Otherwise: the latched direction, with half_rate_limits_i passed through unchanged.
- Pulse outputs last exactly one clk_en-qualified cycle.
- Capture is full RATE_W with no arithmetic. Counters saturate and never wrap.

Optional Feature:
- Macro: LOCKIN_CTRL_STATS_EN.
- With the macro: relock_count_o counts entries into CLEAR from TRACK or LOCKED (violation, timeout, restart). It saturates at 255 and clears only on sync_rst.
- Without the macro: relock_count_o is tied to 0 and the counter logic is absent.

Decomposition:
- In clks_alot_p:
  - lockin_ctrl_state_e (IDLE, CLEAR, ACQUIRE, TRACK, LOCKED; 3 bits);
  - LOCKIN_CTRL_TIMEOUT_W = 16;
  - LOCKIN_CTRL_VIOL_W = 8.
- Sub-module lockin_ctrl_sat_counter: parameterised width and limit, with clear, increment and hit outputs. Reused for the violation, timeout and stats counters.

Test Plan:
- Initial acquisition: reset, enable = 1, update_rate with accumulator = 100 → CLEAR for 1 cycle, ACQUIRE; active_rate_o = 100; valid = 1; state TRACK.
- Direction latch: in TRACK, drift_detected with PIN_CAME_EARLY and update_rate → active_drift_direction_o = EARLY; full_drift_direction_en = 0. A later LATE drift leaves the direction unchanged.
- Violation limit: MAX_VIOLATIONS = 4, four violations with no update → CLEAR; valid = 0. Three violations, then an update, then three more → no CLEAR.
- Timeout: ACQ_TIMEOUT = 10, locked_in held 0 in TRACK → timeout_o pulses after 10 clk_en cycles, then CLEAR.
- Lock loss and priority: LOCKED, locked_in drops → lock_lost_o pulse, TRACK, rate retained. restart_i and ~enable_i together → IDLE.
- Stats build: with LOCKIN_CTRL_STATS_EN, 3 restarts → relock_count_o = 3. Without the macro → 0.
